// File: rtl/pc_fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
//   Shared types and constants for the MIPS front-end fetch sequencer.
//   Contents:
//     PC_W              program counter / address width (32)
//     DEF_RESET_VECTOR  default PC loaded on Reset
//     DEF_EXC_VECTOR    default exception handler address (PC_EXC_EN builds)
//     DEF_PC_INC        default sequential PC increment in bytes
//     fetch_state_e     fetch FSM states
//     word_align()      clears address bits [1:0]
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam logic [PC_W-1:0] DEF_PC_INC       = 32'd4;

  // S_BOOT : one idle cycle after Reset before the first request
  // S_REQ  : presenting a fetch request for pc
  // S_WAIT : live fetch outstanding, response will be captured
  // S_DRAIN: stale fetch outstanding, response will be dropped
  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } fetch_state_e;

  // Instructions are word aligned; redirect targets are forced onto a word.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~{{(PC_W-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer_if
//   Split-transaction instruction memory port.
//   Signals:
//     imem_req     fetch request valid                  (master -> slave)
//     imem_addr    fetch address, stable while stalled  (master -> slave)
//     imem_gnt     request accepted this cycle          (slave -> master)
//     imem_rvalid  response valid, one per grant        (slave -> master)
//     imem_rdata   response instruction word            (slave -> master)
//   Modports: master (fetch sequencer), slave (instruction memory).
// -----------------------------------------------------------------------------
interface pc_fetch_sequencer_if;
  import mips_fetch_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [PC_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_redirect_sel.sv
// -----------------------------------------------------------------------------
// pc_redirect_sel
//   Combinational priority select between the redirect sources feeding the PC.
//   Priority: exc > jmp > br_taken (exc only exists when PC_EXC_EN is defined).
//   Ports:
//     exc         in   1   exception redirect (PC_EXC_EN only)
//     jmp         in   1   jump / jump-register redirect
//     jmp_target  in   32  jump target
//     br_taken    in   1   branch redirect
//     br_target   in   32  branch target
//     redirect    out  1   any redirect requested this cycle
//     target      out  32  winning target with bits [1:0] cleared
//   Configuration macro: PC_EXC_EN adds the exc input and EXC_VECTOR.
// -----------------------------------------------------------------------------
module pc_redirect_sel
  import mips_fetch_pkg::*;
`ifdef PC_EXC_EN
#(
  parameter logic [PC_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
)
`endif
(
`ifdef PC_EXC_EN
  input  logic            exc,
`endif
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            redirect,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] raw_target;

  // Lowest priority source is written first; later writes override, so the
  // textual order below is the priority order.
  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    redirect   = br_taken | jmp;
    raw_target = br_target;
    if (jmp) raw_target = jmp_target;
`ifdef PC_EXC_EN
    redirect = redirect | exc;
    if (exc) raw_target = EXC_VECTOR;
`endif
    target = word_align(raw_target);
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//   Owns the program counter and sequences instruction fetch over a
//   split-transaction imem port. At most one fetch is outstanding and one
//   instruction is buffered for decode. Redirects that land while a fetch is
//   in flight mark it stale; its response is dropped when it returns.
//   Ports:
//     clk          in   1   clock
//     Reset        in   1   synchronous active-high reset
//     stall        in   1   decode cannot accept; holds the inst buffer
//     br_taken     in   1   branch redirect request
//     br_target    in   32  branch target
//     jmp          in   1   jump redirect request
//     jmp_target   in   32  jump target
//     imem         if       pc_fetch_sequencer_if.master
//     pc           out  32  current fetch PC (also drives imem_addr)
//     inst_valid   out  1   inst/inst_pc hold an instruction for decode
//     inst         out  32  buffered instruction
//     inst_pc      out  32  address of buffered instruction
//     exc          in   1   exception redirect          (PC_EXC_EN only)
//     exc_pc       in   32  PC of faulting instruction  (PC_EXC_EN only)
//     epc          out  32  saved exception PC          (PC_EXC_EN only)
//   Configuration macro: PC_EXC_EN adds the exception redirect and epc.
// -----------------------------------------------------------------------------
module pc_fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
`ifdef PC_EXC_EN
  parameter logic [PC_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
`endif
  parameter logic [PC_W-1:0] PC_INC       = DEF_PC_INC
)(
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        stall,
  input  logic                        br_taken,
  input  logic [PC_W-1:0]             br_target,
  input  logic                        jmp,
  input  logic [PC_W-1:0]             jmp_target,
  pc_fetch_sequencer_if.master        imem,
  output logic [PC_W-1:0]             pc,
  output logic                        inst_valid,
  output logic [PC_W-1:0]             inst,
  output logic [PC_W-1:0]             inst_pc
`ifdef PC_EXC_EN
  ,
  input  logic                        exc,
  input  logic [PC_W-1:0]             exc_pc,
  output logic [PC_W-1:0]             epc
`endif
);

  fetch_state_e    state_q, state_d;
  logic            redirect;
  logic [PC_W-1:0] redirect_target;
  logic            fetch_req;
  logic            capture;
  logic [PC_W-1:0] pc_d;
  logic            inst_valid_d;

  pc_redirect_sel
`ifdef PC_EXC_EN
  #(
    .EXC_VECTOR (EXC_VECTOR)
  )
`endif
  u_redirect_sel (
`ifdef PC_EXC_EN
    .exc        (exc),
`endif
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .redirect   (redirect),
    .target     (redirect_target)
  );

  // Next-state and request logic. A request is only raised when the buffer
  // will be free at the edge, so a capture never overwrites an instruction
  // that decode has not taken yet.
  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        fetch_req = !inst_valid || !stall;
        if (fetch_req && imem.imem_gnt) state_d = redirect ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          capture = !redirect;
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Redirect wins over sequential advance in every state (latest target wins
  // while draining). Buffer: redirect flushes, capture fills, consume empties.
  always_comb begin
    pc_d         = pc;
    inst_valid_d = inst_valid;
    if (redirect) begin
      pc_d         = redirect_target;
      inst_valid_d = 1'b0;
    end else if (capture) begin
      pc_d         = pc + PC_INC;
      inst_valid_d = 1'b1;
    end else if (inst_valid && !stall) begin
      inst_valid_d = 1'b0;
    end
  end

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = pc;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= S_BOOT;
      pc         <= RESET_VECTOR;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      inst_valid <= inst_valid_d;
      // inst_pc takes the pre-edge pc: in S_WAIT pc still holds the address
      // that was granted.
      if (capture) begin
        inst    <= imem.imem_rdata;
        inst_pc <= pc;
      end
    end
  end

`ifdef PC_EXC_EN
  always_ff @(posedge clk) begin
    if (Reset)    epc <= '0;
    else if (exc) epc <= exc_pc;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//   Directed vector table, hand-written corner sequences, and a randomized
//   run against a transaction-level reference model of the fetch front end.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic [31:0] pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef PC_EXC_EN
  logic        exc;
  logic [31:0] exc_pc;
  logic [31:0] epc;
`endif

  pc_fetch_sequencer_if imem_bus();

  pc_fetch_sequencer dut (
    .clk        (clk),
    .Reset      (Reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .imem       (imem_bus),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
`ifdef PC_EXC_EN
    ,
    .exc        (exc),
    .exc_pc     (exc_pc),
    .epc        (epc)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_t;
    logic        jmp;
    logic [31:0] jmp_t;
    logic        gnt;
    logic        rv;
    logic [31:0] rd_addr;   // address whose memory word is returned on rv
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t tab[28];
  vec_t seq[6];

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall                = 1'b0;
    br_taken             = 1'b0;
    br_target            = '0;
    jmp                  = 1'b0;
    jmp_target           = '0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
`ifdef PC_EXC_EN
    exc    = 1'b0;
    exc_pc = '0;
`endif
  endtask

  // Holds Reset over one edge and checks the reset state. Reset is released
  // by the next apply_row, so that row is the S_BOOT cycle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    clear_inputs();
    Reset = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".rst.pc"},  pc, 32'h0);
    check({tag, ".rst.iv"},  {31'b0, inst_valid}, 32'h0);
    check({tag, ".rst.inst"}, inst, 32'h0);
    check({tag, ".rst.ipc"}, inst_pc, 32'h0);
    check({tag, ".rst.req"}, {31'b0, imem_bus.imem_req}, 32'h0);
`ifdef PC_EXC_EN
    check({tag, ".rst.epc"}, epc, 32'h0);
`endif
  endtask

  task automatic apply_row(input vec_t v, input string tag);
    @(negedge clk);
    Reset                = 1'b0;
    stall                = v.stall;
    br_taken             = v.br;
    br_target            = v.br_t;
    jmp                  = v.jmp;
    jmp_target           = v.jmp_t;
    imem_bus.imem_gnt    = v.gnt;
    imem_bus.imem_rvalid = v.rv;
    imem_bus.imem_rdata  = mem_word(v.rd_addr);
    #1;
    check({tag, ".req"}, {31'b0, imem_bus.imem_req}, {31'b0, v.exp_req});
    check({tag, ".addr"}, imem_bus.imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc, v.exp_pc);
    check({tag, ".iv"}, {31'b0, inst_valid}, {31'b0, v.exp_iv});
    check({tag, ".ipc"}, inst_pc, v.exp_ipc);
    if (v.exp_iv) check({tag, ".inst"}, inst, mem_word(v.exp_ipc));
  endtask

  // Reference model state: architectural fetch PC, one outstanding fetch
  // (address and whether its response is still wanted), decode buffer.
  logic        m_boot, m_pend, m_live, m_bv;
  logic [31:0] m_pc, m_faddr, m_ipc, m_inst;
  logic        r_busy;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic        redir, exp_req, grant, captured, dut_req;
  logic [31:0] tgt, dut_addr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    Reset = 1'b1;

    // -- directed table: sequential fetch, stall, mid-fetch branch,
    //    jmp over branch with rvalid, redirects while stalled / granting / draining
    //           stall br  br_t        jmp jmp_t       gnt rv  rd_addr      req addr        pc          iv  ipc
    tab[0]  = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h0};
    tab[1]  = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h0};
    tab[2]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h0,   0, 32'h0,   32'h4,   1, 32'h0};
    tab[3]  = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h4,   32'h4,   0, 32'h0};
    tab[4]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h4,   0, 32'h4,   32'h8,   1, 32'h4};
    tab[5]  = '{1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h8,   32'h8,   1, 32'h4};
    tab[6]  = '{1, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 32'h8,   32'h8,   1, 32'h4};
    tab[7]  = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h8,   32'h8,   0, 32'h4};
    tab[8]  = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h8,   0, 32'h8,   32'hC,   1, 32'h8};
    tab[9]  = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'hC,   32'hC,   0, 32'h8};
    tab[10] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'hC,   0, 32'hC,   32'h10,  1, 32'hC};
    tab[11] = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h10,  32'h10,  0, 32'hC};
    tab[12] = '{0, 1, 32'h40,  0, 32'h0,   0, 0, 32'h0,   0, 32'h10,  32'h40,  0, 32'hC};
    tab[13] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h10,  0, 32'h40,  32'h40,  0, 32'hC};
    tab[14] = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h40,  32'h40,  0, 32'hC};
    tab[15] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h40,  0, 32'h40,  32'h44,  1, 32'h40};
    tab[16] = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h44,  32'h44,  0, 32'h40};
    tab[17] = '{0, 1, 32'h40,  1, 32'h100, 0, 1, 32'h44,  0, 32'h44,  32'h100, 0, 32'h40};
    tab[18] = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h100, 32'h100, 0, 32'h40};
    tab[19] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h100, 0, 32'h100, 32'h104, 1, 32'h100};
    tab[20] = '{1, 1, 32'h203, 0, 32'h0,   0, 0, 32'h0,   0, 32'h104, 32'h200, 0, 32'h100};
    tab[21] = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h200, 32'h200, 0, 32'h100};
    tab[22] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200, 0, 32'h200, 32'h204, 1, 32'h200};
    tab[23] = '{0, 0, 32'h0,   1, 32'h300, 1, 0, 32'h0,   1, 32'h204, 32'h300, 0, 32'h200};
    tab[24] = '{0, 1, 32'h500, 0, 32'h0,   0, 0, 32'h0,   0, 32'h300, 32'h500, 0, 32'h200};
    tab[25] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h204, 0, 32'h500, 32'h500, 0, 32'h200};
    tab[26] = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h500, 32'h500, 0, 32'h200};
    tab[27] = '{0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h500, 0, 32'h500, 32'h504, 1, 32'h500};

    do_reset("tab");
    for (int i = 0; i < 28; i++) apply_row(tab[i], $sformatf("tab%0d", i));

    // -- PC wrap at the top of memory, then an unaligned jump target
    seq[0] = '{0, 0, 32'h0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0,         0, 32'h0};
    seq[1] = '{0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         1, 32'h0,         32'hFFFF_FFFC, 0, 32'h0};
    seq[2] = '{0, 0, 32'h0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0};
    seq[3] = '{0, 0, 32'h0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'hFFFF_FFFC};
    seq[4] = '{0, 0, 32'h0, 1, 32'h103,       0, 0, 32'h0,         1, 32'h0,         32'h100,       0, 32'hFFFF_FFFC};
    seq[5] = '{0, 0, 32'h0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'h100,       0, 32'hFFFF_FFFC};
    do_reset("wrap");
    for (int i = 0; i < 6; i++) apply_row(seq[i], $sformatf("wrap%0d", i));

    // -- Reset while a fetch is outstanding; the late response arrives in
    //    S_BOOT and S_REQ and must be ignored
    do_reset("mid");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,   0, 32'h0, 32'h0, 0, 32'h0}, "mid0");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0,   1, 32'h0, 32'h0, 0, 32'h0}, "mid1");
    do_reset("mid");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0,   0, 32'h0, 32'h0, 0, 32'h0}, "mid2");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0,   1, 32'h0, 32'h0, 0, 32'h0}, "mid3");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0,   1, 32'h0, 32'h0, 0, 32'h0}, "mid4");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0,   0, 32'h0, 32'h4, 1, 32'h0}, "mid5");

`ifdef PC_EXC_EN
    // -- exception beats jmp on a granted request; epc captures exc_pc
    do_reset("exc");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0}, "exc0");
    exc    = 1'b1;
    exc_pc = 32'h2C;
    apply_row('{0, 1, 32'h40, 1, 32'h100, 1, 0, 32'h0, 1, 32'h0, 32'h8000_0180, 0, 32'h0}, "exc1");
    check("exc1.epc", epc, 32'h2C);
    exc    = 1'b0;
    exc_pc = 32'h0;
    apply_row('{0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h8000_0180, 32'h8000_0180, 0, 32'h0}, "exc2");
    apply_row('{0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h8000_0180, 32'h8000_0180, 0, 32'h0}, "exc3");
    check("exc3.epc", epc, 32'h2C);
`endif

    // -- randomized traffic against the reference model
    do_reset("rnd");
    m_boot = 1'b1; m_pend = 1'b0; m_live = 1'b0; m_bv = 1'b0;
    m_pc = 32'h0; m_faddr = 32'h0; m_ipc = 32'h0; m_inst = 32'h0;
    r_busy = 1'b0; r_cnt = 2'd0; r_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      Reset                = 1'b0;
      stall                = ($urandom_range(0, 3) == 0);
      br_taken             = ($urandom_range(0, 9) == 0);
      br_target            = $urandom;
      jmp                  = ($urandom_range(0, 19) == 0);
      jmp_target           = $urandom;
      imem_bus.imem_gnt    = ($urandom_range(0, 2) != 0);
      imem_bus.imem_rvalid = r_busy && (r_cnt == 2'd0);
      imem_bus.imem_rdata  = imem_bus.imem_rvalid ? mem_word(r_addr) : $urandom;
      #1;
      redir   = jmp || br_taken;
      tgt     = jmp ? {jmp_target[31:2], 2'b00} : {br_target[31:2], 2'b00};
      exp_req = !m_boot && !m_pend && (!m_bv || !stall);
      check("rnd.req", {31'b0, imem_bus.imem_req}, {31'b0, exp_req});
      if (exp_req) check("rnd.addr", imem_bus.imem_addr, m_pc);
      dut_req  = imem_bus.imem_req;
      dut_addr = imem_bus.imem_addr;
      @(posedge clk);
      #1;
      // model update from the pre-edge inputs
      grant    = exp_req && imem_bus.imem_gnt;
      captured = 1'b0;
      if (m_pend && imem_bus.imem_rvalid) begin
        m_pend = 1'b0;
        if (m_live && !redir) begin
          captured = 1'b1;
          m_bv     = 1'b1;
          m_inst   = mem_word(m_faddr);
          m_ipc    = m_faddr;
          m_pc     = m_faddr + 32'd4;
        end
      end
      if (!captured && m_bv && !stall) m_bv = 1'b0;
      if (grant) begin
        m_pend  = 1'b1;
        m_live  = !redir;
        m_faddr = m_pc;
      end
      if (redir) begin
        m_pc   = tgt;
        m_live = 1'b0;
        m_bv   = 1'b0;
      end
      m_boot = 1'b0;
      // memory responder
      if (imem_bus.imem_rvalid) r_busy = 1'b0;
      else if (r_busy)          r_cnt  = r_cnt - 2'd1;
      if (dut_req && imem_bus.imem_gnt) begin
        r_busy = 1'b1;
        r_addr = dut_addr;
        r_cnt  = 2'($urandom_range(0, 2));
      end
      check("rnd.pc", pc, m_pc);
      check("rnd.iv", {31'b0, inst_valid}, {31'b0, m_bv});
      if (m_bv) begin
        check("rnd.ipc",  inst_pc, m_ipc);
        check("rnd.inst", inst, m_inst);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
